serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHALL be >= 2.
REQ-002 Parameter DIGIT, default 1, bits added per cycle; SHALL divide WIDTH exactly (elaboration error otherwise).
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port start  input  1  request an operation; sampled only when not busy.
REQ-006 Port sub  input  1  0 = A+B, 1 = A-B; latched with operands.
REQ-007 Port A  input  WIDTH  operand A, latched on accepted start.
REQ-008 Port B  input  WIDTH  operand B, latched on accepted start.
REQ-009 Port busy  output  1  high while digits are being processed.
REQ-010 Port done  output  1  one-cycle pulse; result valid.
REQ-011 Port sum  output  WIDTH  result, held until the next completion.
REQ-012 Port cout  output  1  carry out of MSB (for sub: 1 = no borrow).
REQ-013 Port ovf  output  1  two's-complement signed overflow.

Function
REQ-014 FSM states IDLE, RUN, DONE; only these three.
REQ-015 IDLE: start=1 SHALL latch A, B, sub, clear digit counter, load carry = sub, go RUN.
REQ-016 RUN: each cycle SHALL add digit i of A and (B XOR {WIDTH{sub}}) plus stored carry, write DIGIT result bits at digit i, store carry out, increment counter.
REQ-017 Digit order SHALL be LSB first; N = WIDTH/DIGIT RUN cycles per operation.
REQ-018 On the last RUN cycle the FSM SHALL go DONE; sum, cout, ovf update at that edge.
REQ-019 ovf SHALL equal carry-into-MSB XOR carry-out-of-MSB of the final digit.
REQ-020 Latency: start accepted at edge k -> busy high cycles k+1..k+N, done high exactly cycle k+N+1.
REQ-021 DONE: done=1, busy=0; start=1 in DONE SHALL be accepted as in IDLE (back-to-back); else go IDLE.
REQ-022 start while busy SHALL be ignored; latched operands and progress unaffected.
REQ-023 A/B/sub changes after acceptance SHALL NOT affect the result.
REQ-024 sum/cout/ovf SHALL NOT change during RUN; they change only at the REQ-018 edge.
REQ-025 Wrap-around: sum is modulo 2^WIDTH; the carry out of the MSB goes only to cout.

Reset
REQ-026 reset_n low SHALL immediately force state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, counter=0, stored carry=0.
REQ-027 Reset during RUN SHALL abort the operation; no done pulse is generated for it.
REQ-028 The first start after reset_n deasserts SHALL be accepted normally.

Structure
REQ-029 Package serial_adder_pkg SHALL hold the state enum type and the default WIDTH/DIGIT constants.
REQ-030 One sub-module fa_cell (1-bit full adder: sum = a^b^c, cout = a&b | c&(a^b)) SHALL be instantiated DIGIT times as a ripple chain.
REQ-031 Counter width SHALL be $clog2(N) with a minimum of 1 bit.

Verification
REQ-032 WIDTH=8, DIGIT=1: A=8'h3C, B=8'h0F, sub=0 -> sum=8'h4B, cout=0, ovf=0; done 9 cycles after the start edge.
REQ-033 A=8'h7F, B=8'h01, add -> sum=8'h80, cout=0, ovf=1; A=8'hFF, B=8'h01 -> sum=8'h00, cout=1, ovf=0.
REQ-034 A=8'h05, B=8'h07, sub=1 -> sum=8'hFE, cout=0, ovf=0; A=8'h80, B=8'h01, sub=1 -> sum=8'h7F, ovf=1.
REQ-035 Start pulsed again at the 3rd busy cycle with new operands -> ignored; the original result is returned; a start during done is accepted back-to-back.
REQ-036 reset_n low at the 4th RUN cycle -> all outputs 0 immediately, no done; the next operation is correct.
REQ-037 WIDTH=8, DIGIT=4: A=8'hF0, B=8'h10 -> sum=8'h00, cout=1; busy for 2 cycles, done on the 3rd.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and default sizing for the digit-serial adder/subtractor.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned DIGIT_DEF = 1;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder; purely combinational, chained to form a digit slice.
module fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ c_i;
    assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// Digit-serial add/sub: WIDTH/DIGIT RUN cycles, then a one-cycle done pulse.
// start is accepted in IDLE or DONE only; while busy it is ignored.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DIGIT = DIGIT_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
    logic             cout_q, cout_d, ovf_q, ovf_d;
    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] dsum;
    logic             last;

    // Operands shift right one digit per cycle, so the active digit is always at the LSBs.
    assign c[0] = carry_q;
    for (genvar i = 0; i < DIGIT; i++) begin : g_chain
        fa_cell u_fa (
            .a_i  (a_q[i]),
            .b_i  (b_q[i]),
            .c_i  (c[i]),
            .s_o  (dsum[i]),
            .co_o (c[i+1])
        );
    end

    assign last = (cnt_q == CW'(N - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = A;
                    b_d     = B ^ {WIDTH{sub}};
                    carry_d = sub;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                acc_d   = (acc_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
                carry_d = c[DIGIT];
                cnt_d   = cnt_q + CW'(1);
                if (last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    sum_d   = acc_d;
                    cout_d  = c[DIGIT];
                    ovf_d   = c[DIGIT] ^ c[DIGIT-1];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: one instance per digit size, checked against an arithmetic model.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       start_s [2];
    logic       sub_s   [2];
    logic [7:0] a_s     [2];
    logic [7:0] b_s     [2];
    logic [7:0] sum_s   [2];
    logic       busy_s  [2];
    logic       done_s  [2];
    logic       cout_s  [2];
    logic       ovf_s   [2];

    int         n_dig [2] = '{8, 2};
    logic [7:0] psum  [2];
    logic       pcout [2];
    logic       povf  [2];

    int vectors     = 0;
    int miscompares = 0;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .reset_n(reset_n), .start(start_s[0]), .sub(sub_s[0]),
        .A(a_s[0]), .B(b_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .sum(sum_s[0]), .cout(cout_s[0]), .ovf(ovf_s[0])
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .reset_n(reset_n), .start(start_s[1]), .sub(sub_s[1]),
        .A(a_s[1]), .B(b_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .sum(sum_s[1]), .cout(cout_s[1]), .ovf(ovf_s[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_in(input int w);
        a_s[w]   = 8'($urandom);
        b_s[w]   = 8'($urandom);
        sub_s[w] = 1'($urandom);
    endtask

    // Returns {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
        int   ua, ub, sa, sb, r, sr;
        logic c;
        logic [7:0] rs;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (s) begin
            r  = ua - ub;
            sr = sa - sb;
            c  = (ua >= ub);
        end else begin
            r  = ua + ub;
            sr = sa + sb;
            c  = (r > 255);
        end
        rs = r[7:0];
        return {(sr > 127) || (sr < -128), c, rs};
    endfunction

    task automatic check_outs(input int w, input string tag, input logic [7:0] es,
                              input logic ec, input logic eo);
        check({tag, " sum"},  32'(sum_s[w]),  32'(es));
        check({tag, " cout"}, 32'(cout_s[w]), 32'(ec));
        check({tag, " ovf"},  32'(ovf_s[w]),  32'(eo));
    endtask

    // Starts an operation in the current cycle and ends in its done cycle.
    task automatic do_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic [7:0] es, input logic ec, input logic eo,
                         input int poke, input string tag);
        start_s[w] = 1'b1;
        a_s[w]     = a;
        b_s[w]     = b;
        sub_s[w]   = s;
        tick();
        start_s[w] = 1'b0;
        for (int j = 1; j <= n_dig[w]; j++) begin
            check({tag, " busy"}, 32'(busy_s[w]), 32'd1);
            check({tag, " done_early"}, 32'(done_s[w]), 32'd0);
            check_outs(w, {tag, " hold"}, psum[w], pcout[w], povf[w]);
            start_s[w] = (j == poke);
            rand_in(w);
            tick();
        end
        start_s[w] = 1'b0;
        check({tag, " done"}, 32'(done_s[w]), 32'd1);
        check({tag, " busy_end"}, 32'(busy_s[w]), 32'd0);
        check_outs(w, tag, es, ec, eo);
        psum[w]  = es;
        pcout[w] = ec;
        povf[w]  = eo;
    endtask

    task automatic idle(input int w, input string tag);
        tick();
        check({tag, " idle_done"}, 32'(done_s[w]), 32'd0);
        check({tag, " idle_busy"}, 32'(busy_s[w]), 32'd0);
    endtask

    task automatic rand_op(input int w, input string tag);
        logic [7:0] a, b;
        logic       s;
        logic [9:0] m;
        a = 8'($urandom);
        b = 8'($urandom);
        s = 1'($urandom);
        m = model(a, b, s);
        do_op(w, a, b, s, m[7:0], m[8], m[9], 0, tag);
    endtask

    initial begin
        logic [9:0] m;
        reset_n = 1'b0;
        for (int w = 0; w < 2; w++) begin
            start_s[w] = 1'b0;
            sub_s[w]   = 1'b0;
            a_s[w]     = 8'h00;
            b_s[w]     = 8'h00;
            psum[w]    = 8'h00;
            pcout[w]   = 1'b0;
            povf[w]    = 1'b0;
        end
        #2;
        for (int w = 0; w < 2; w++) begin
            check("reset busy", 32'(busy_s[w]), 32'd0);
            check("reset done", 32'(done_s[w]), 32'd0);
            check_outs(w, "reset", 8'h00, 1'b0, 1'b0);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();

        do_op(0, 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, 0, "add_3c_0f");
        idle(0, "add_3c_0f");
        do_op(0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0, "add_7f_01");
        idle(0, "add_7f_01");
        do_op(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, "add_ff_01");
        idle(0, "add_ff_01");
        do_op(0, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 0, "sub_05_07");
        idle(0, "sub_05_07");
        do_op(0, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 0, "sub_80_01");
        idle(0, "sub_80_01");

        // Restart mid-run is ignored; restart in done is taken back-to-back.
        do_op(0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 3, "busy_poke");
        m = model(8'hA5, 8'h5A, 1'b1);
        do_op(0, 8'hA5, 8'h5A, 1'b1, m[7:0], m[8], m[9], 0, "b2b");
        idle(0, "b2b");

        // Abort at the 4th RUN cycle.
        start_s[0] = 1'b1;
        a_s[0]     = 8'h11;
        b_s[0]     = 8'h22;
        sub_s[0]   = 1'b0;
        tick();
        start_s[0] = 1'b0;
        for (int j = 0; j < 3; j++) tick();
        check("abort busy_before", 32'(busy_s[0]), 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort busy", 32'(busy_s[0]), 32'd0);
        check("abort done", 32'(done_s[0]), 32'd0);
        check_outs(0, "abort", 8'h00, 1'b0, 1'b0);
        for (int w = 0; w < 2; w++) begin
            psum[w]  = 8'h00;
            pcout[w] = 1'b0;
            povf[w]  = 1'b0;
        end
        tick();
        reset_n = 1'b1;
        for (int j = 0; j < 10; j++) begin
            tick();
            check("abort no_done", 32'(done_s[0]), 32'd0);
        end
        do_op(0, 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, 0, "after_reset");
        idle(0, "after_reset");

        do_op(1, 8'hF0, 8'h10, 1'b0, 8'h00, 1'b1, 1'b0, 0, "d4_f0_10");
        idle(1, "d4_f0_10");

        for (int i = 0; i < 20; i++) begin
            rand_op(0, "rand_d1");
            if ($urandom_range(1) == 0) idle(0, "rand_d1");
        end
        for (int i = 0; i < 10; i++) begin
            rand_op(1, "rand_d4");
            if ($urandom_range(1) == 0) idle(1, "rand_d4");
        end
        idle(0, "tail");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
